// File: rtl/north_buffer_ctrl.sv
// Load/read sequencer for the weight-stationary North buffer: one LOAD phase, then N READ passes.
// Optional NORTH_BUFFER_CTRL_PERF_EN adds stall_cycles / load_idle_cycles performance counters.
module north_buffer_ctrl #(
  parameter int TOTAL_MODULES = 3,
  parameter int COL_X         = 16,
  parameter int MAX_PASSES    = 16,
  parameter int ADDR_WIDTH    = (COL_X > 1) ? $clog2(COL_X) : 1,
  parameter int PASS_WIDTH    = $clog2(MAX_PASSES + 1),
  parameter int SIDX_WIDTH    = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SIDX_WIDTH-1:0] cfg_slice_idx,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SIDX_WIDTH-1:0] slicing_idx,
  input  logic                  rd_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
`ifdef NORTH_BUFFER_CTRL_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           load_idle_cycles,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COL_X - 1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [PASS_WIDTH-1:0]   pass_cnt_q;
  logic [PASS_WIDTH-1:0]   passes_q;
  logic [SIDX_WIDTH-1:0]   slice_q;
  logic                    rd_valid_q;
  logic                    rd_last_q;
  logic                    done_q;
  logic                    last_pass;
  logic                    rd_last_d;

  // flush takes priority: no write or read is issued in the abort cycle
  always_comb begin
    in_ready  = (state_q == LOAD) && !flush;
    wr_en     = in_valid && in_ready;
    rd_en     = (state_q == READ) && rd_ready && !flush;
    last_pass = (pass_cnt_q == passes_q - PASS_WIDTH'(1));
    rd_last_d = rd_en && (rd_addr_q == LAST_ADDR) && last_pass;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      pass_cnt_q <= '0;
      passes_q   <= '0;
      slice_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_last_d;
      done_q     <= 1'b0;
      if (flush) begin
        state_q    <= IDLE;
        wr_addr_q  <= '0;
        rd_addr_q  <= '0;
        pass_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= LOAD;
              slice_q    <= cfg_slice_idx;
              passes_q   <= (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
              wr_addr_q  <= '0;
              rd_addr_q  <= '0;
              pass_cnt_q <= '0;
            end
          end
          LOAD: begin
            if (wr_en) begin
              if (wr_addr_q == LAST_ADDR) begin
                wr_addr_q <= '0;
                state_q   <= READ;
              end else begin
                wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
              end
            end
          end
          READ: begin
            if (rd_en) begin
              if (rd_addr_q == LAST_ADDR) begin
                rd_addr_q <= '0;
                if (last_pass) begin
                  pass_cnt_q <= '0;
                  state_q    <= DRAIN;
                  done_q     <= 1'b1;
                end else begin
                  pass_cnt_q <= pass_cnt_q + PASS_WIDTH'(1);
                end
              end else begin
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
              end
            end
          end
          DRAIN: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef NORTH_BUFFER_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] load_idle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q     <= '0;
      load_idle_cnt_q <= '0;
    end else if (state_q == IDLE && start && !flush) begin
      stall_cnt_q     <= '0;
      load_idle_cnt_q <= '0;
    end else begin
      if (state_q == READ && !rd_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == LOAD && !in_valid && load_idle_cnt_q != '1)
        load_idle_cnt_q <= load_idle_cnt_q + 32'd1;
    end
  end

  assign stall_cycles     = stall_cnt_q;
  assign load_idle_cycles = load_idle_cnt_q;
`endif

  assign wr_addr     = wr_addr_q;
  assign rd_addr     = rd_addr_q;
  assign slicing_idx = slice_q;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule
